// File: rtl/div_unit_if.sv
// Handshake/operand bundle for div_unit: requester drives start/operands and
// observes the registered results and status flags.
interface div_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic             sign;
   logic             cancel;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic             overflow;

   modport master (
      output start, sign, cancel, a, b,
      input  q, r, busy, done, div_zero, overflow
   );

   modport slave (
      input  start, sign, cancel, a, b,
      output q, r, busy, done, div_zero, overflow
   );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring integer divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to skip leading-zero iterations; results are unchanged.
module div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input logic       clk,
   input logic       rst,
   div_unit_if.slave bus
);
   localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] IterFull = CNT_W'(WIDTH);
   localparam logic [WIDTH-1:0] MinVal   = {1'b1, {(WIDTH - 1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

   state_e           state_q, state_d;
   // div_q shifts dividend bits out of the top and quotient bits in at the bottom
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] mag_b_q, mag_b_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             div_zero_q, div_zero_d;
   logic             overflow_q, overflow_d;

   logic [WIDTH-1:0] mag_a_in, mag_b_in;
   logic [CNT_W-1:0] iters;
   logic [WIDTH-1:0] rem_init, div_init;
   logic [WIDTH:0]   trial;

   assign mag_a_in = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign mag_b_in = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;

`ifdef DIV_EARLY_OUT_EN
   function automatic logic [CNT_W-1:0] clz(input logic [WIDTH-1:0] v);
      logic [CNT_W-1:0] n;
      logic             found;
      n     = '0;
      found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      n = n + CNT_W'(1);
         end
      end
      return n;
   endfunction

   logic [CNT_W-1:0] lz_a, lz_b;
   assign lz_a  = clz(mag_a_in);
   assign lz_b  = clz(mag_b_in);
   // Only reached when |a| >= |b|, so lz_b >= lz_a. The bits above the first
   // iters positions preload the remainder, which stays below |b|.
   assign iters    = lz_b - lz_a + CNT_W'(1);
   assign rem_init = mag_a_in >> iters;
   assign div_init = mag_a_in << (IterFull - iters);
`else
   assign iters    = IterFull;
   assign rem_init = '0;
   assign div_init = mag_a_in;
`endif

   assign trial = {rem_q, div_q[WIDTH-1]} - {1'b0, mag_b_q};

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      rem_d      = rem_q;
      mag_b_d    = mag_b_q;
      cnt_d      = cnt_q;
      q_neg_d    = q_neg_q;
      r_neg_d    = r_neg_q;
      q_d        = q_q;
      r_d        = r_q;
      done_d     = 1'b0;
      div_zero_d = 1'b0;
      overflow_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.start && !bus.cancel) begin
               if (bus.b == '0) begin
                  q_d        = '1;
                  r_d        = bus.a;
                  div_zero_d = 1'b1;
                  done_d     = 1'b1;
               end else if (bus.sign && bus.a == MinVal && bus.b == '1) begin
                  q_d        = MinVal;
                  r_d        = '0;
                  overflow_d = 1'b1;
                  done_d     = 1'b1;
               end else if (mag_a_in < mag_b_in) begin
                  q_d    = '0;
                  r_d    = bus.a;
                  done_d = 1'b1;
               end else begin
                  state_d = StCalc;
                  div_d   = div_init;
                  rem_d   = rem_init;
                  mag_b_d = mag_b_in;
                  cnt_d   = iters;
                  q_neg_d = bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  r_neg_d = bus.sign & bus.a[WIDTH-1];
               end
            end
         end
         StCalc: begin
            if (bus.cancel) begin
               state_d = StIdle;
            end else begin
               if (!trial[WIDTH]) begin
                  rem_d = trial[WIDTH-1:0];
                  div_d = {div_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_d = {rem_q[WIDTH-2:0], div_q[WIDTH-1]};
                  div_d = {div_q[WIDTH-2:0], 1'b0};
               end
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_d = StFin;
            end
         end
         StFin: begin
            state_d = StIdle;
            if (!bus.cancel) begin
               q_d    = q_neg_q ? -div_q : div_q;
               r_d    = r_neg_q ? -rem_q : rem_q;
               done_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         div_q      <= '0;
         rem_q      <= '0;
         mag_b_q    <= '0;
         cnt_q      <= '0;
         q_neg_q    <= 1'b0;
         r_neg_q    <= 1'b0;
         q_q        <= '0;
         r_q        <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         rem_q      <= rem_d;
         mag_b_q    <= mag_b_d;
         cnt_q      <= cnt_d;
         q_neg_q    <= q_neg_d;
         r_neg_q    <= r_neg_d;
         q_q        <= q_d;
         r_q        <= r_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.q        = q_q;
   assign bus.r        = r_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.div_zero = div_zero_q;
   assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: a 32-bit instance checked against a behavioural
// model, plus a few directed operations on an 8-bit instance.
module tb_div_unit;
   logic clk = 1'b0;
   logic rst;
   int   edges = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) edges <= edges + 1;

   div_unit_if #(.WIDTH(32)) bus ();
   div_unit_if #(.WIDTH(8))  bus8 ();

   div_unit #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   div_unit #(.WIDTH(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      logic        ov;
      int          lat;
      int          t0;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int clz32(input longint v);
      int n = 0;
      for (int i = 31; i >= 0; i--) begin
         if (v[i]) return n;
         n++;
      end
      return n;
   endfunction

   function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint sa, dv, ma, mb;
      e.dz = 1'b0;
      e.ov = 1'b0;
      e.t0 = 0;
      if (b == 32'h0) begin
         e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1; e.lat = 1;
         return e;
      end
      if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.q = 32'h8000_0000; e.r = 32'h0; e.ov = 1'b1; e.lat = 1;
         return e;
      end
      if (s) begin
         sa = longint'($signed(a));
         dv = longint'($signed(b));
      end else begin
         sa = longint'({32'h0, a});
         dv = longint'({32'h0, b});
      end
      e.q = 32'(sa / dv);
      e.r = 32'(sa % dv);
      ma  = (sa < 0) ? -sa : sa;
      mb  = (dv < 0) ? -dv : dv;
      if (ma < mb) e.lat = 1;
`ifdef DIV_EARLY_OUT_EN
      else e.lat = clz32(mb) - clz32(ma) + 3;
`else
      else e.lat = 34;
`endif
      return e;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 20));
         5:       return $urandom >> $urandom_range(0, 31);
         default: return $urandom;
      endcase
   endfunction

   // Called at a negedge; returns one negedge later with start dropped.
   task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input bit push);
      exp_t e;
      bus.start = 1'b1;
      bus.sign  = s;
      bus.a     = a;
      bus.b     = b;
      if (push) begin
         e    = model(s, a, b);
         e.t0 = edges;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         check("drain_timeout", 64'(sb.size()), 64'h0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er, input logic ez,
                       input logic eo, input int elat);
      int t0;
      bus8.start = 1'b1;
      bus8.sign  = s;
      bus8.a     = a;
      bus8.b     = b;
      t0         = edges;
      @(negedge clk);
      bus8.start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus8.done) break;
         @(negedge clk);
      end
      check("w8_done", 64'(bus8.done), 64'h1);
      check("w8_q", 64'(bus8.q), 64'(eq));
      check("w8_r", 64'(bus8.r), 64'(er));
      check("w8_div_zero", 64'(bus8.div_zero), 64'(ez));
      check("w8_overflow", 64'(bus8.overflow), 64'(eo));
      check("w8_latency", 64'(edges - t0), 64'(elat));
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            check("spurious_done", 64'h1, 64'h0);
         end else begin
            e = sb.pop_front();
            check("q", 64'(bus.q), 64'(e.q));
            check("r", 64'(bus.r), 64'(e.r));
            check("div_zero", 64'(bus.div_zero), 64'(e.dz));
            check("overflow", 64'(bus.overflow), 64'(e.ov));
            check("latency", 64'(edges - e.t0), 64'(e.lat));
            check("busy_at_done", 64'(bus.busy), 64'h0);
         end
      end else if (bus.div_zero === 1'b1 || bus.overflow === 1'b1) begin
         check("flag_without_done", 64'h1, 64'h0);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int nb;
      rst         = 1'b0;
      bus.start   = 1'b0;
      bus.sign    = 1'b0;
      bus.cancel  = 1'b0;
      bus.a       = '0;
      bus.b       = '0;
      bus8.start  = 1'b0;
      bus8.sign   = 1'b0;
      bus8.cancel = 1'b0;
      bus8.a      = '0;
      bus8.b      = '0;
      repeat (3) @(negedge clk);
      check("rst_q", 64'(bus.q), 64'h0);
      check("rst_r", 64'(bus.r), 64'h0);
      check("rst_busy", 64'(bus.busy), 64'h0);
      check("rst_done", 64'(bus.done), 64'h0);
      check("rst_div_zero", 64'(bus.div_zero), 64'h0);
      check("rst_overflow", 64'(bus.overflow), 64'h0);
      rst = 1'b1;
      @(negedge clk);

      // Unsigned timing: busy for every cycle between start and done.
      launch(1'b0, 32'd100, 32'd7, 1'b1);
      nb = 0;
      for (int i = 0; i < 100; i++) begin
         if (bus.done) break;
         if (bus.busy) nb++;
         @(negedge clk);
      end
`ifdef DIV_EARLY_OUT_EN
      check("busy_cycles", 64'(nb), 64'd6);
`else
      check("busy_cycles", 64'(nb), 64'd33);
`endif
      @(negedge clk);
      check("done_one_cycle", 64'(bus.done), 64'h0);
      drain();

      launch(1'b1, -32'sd100, 32'd7, 1'b1);
      drain();
      launch(1'b1, 32'd100, -32'sd7, 1'b1);
      drain();
      launch(1'b1, -32'sd100, -32'sd7, 1'b1);
      drain();

      launch(1'b0, 32'h1234, 32'h0, 1'b1);
      check("dz_busy_low", 64'(bus.busy), 64'h0);
      drain();
      launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      drain();
      launch(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      drain();

      // Back-to-back: second start lands in the done cycle; a mid-CALC start is ignored.
      launch(1'b0, 32'd1000, 32'd10, 1'b1);
      for (int i = 0; i < 100; i++) begin
         if (bus.done) break;
         @(negedge clk);
      end
      launch(1'b0, 32'd999, 32'd3, 1'b1);
      repeat (2) @(negedge clk);
      launch(1'b0, 32'd5, 32'd0, 1'b0);
      drain();

      // Cancel on the 5th CALC cycle: results hold 333/0.
      launch(1'b0, 32'd100, 32'd7, 1'b0);
      repeat (4) @(negedge clk);
      bus.cancel = 1'b1;
      @(negedge clk);
      bus.cancel = 1'b0;
      check("cancel_busy", 64'(bus.busy), 64'h0);
      check("cancel_done", 64'(bus.done), 64'h0);
      check("cancel_q_hold", 64'(bus.q), 64'd333);
      check("cancel_r_hold", 64'(bus.r), 64'd0);
      repeat (40) @(negedge clk);
      check("cancel_q_late", 64'(bus.q), 64'd333);

      // Reset mid-operation clears everything.
      launch(1'b0, 32'd100, 32'd7, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("mid_rst_q", 64'(bus.q), 64'h0);
      check("mid_rst_r", 64'(bus.r), 64'h0);
      check("mid_rst_busy", 64'(bus.busy), 64'h0);
      check("mid_rst_done", 64'(bus.done), 64'h0);
      repeat (40) @(negedge clk);
      check("mid_rst_q_late", 64'(bus.q), 64'h0);

      // start+cancel in IDLE: the divide-by-zero completion must not fire.
      bus.cancel = 1'b1;
      launch(1'b0, 32'h1234, 32'h0, 1'b0);
      bus.cancel = 1'b0;
      check("sc_done", 64'(bus.done), 64'h0);
      check("sc_busy", 64'(bus.busy), 64'h0);
      check("sc_q", 64'(bus.q), 64'h0);
      check("sc_div_zero", 64'(bus.div_zero), 64'h0);
      @(negedge clk);

      for (int m = 0; m < 2; m++) begin
         for (int k = 0; k < 150; k++) begin
            launch(logic'(m), pick(), pick(), 1'b1);
            drain();
         end
      end

`ifdef DIV_EARLY_OUT_EN
      run8(1'b0, 8'd255, 8'd16, 8'd15, 8'd15, 1'b0, 1'b0, 6);
      run8(1'b1, 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 1'b0, 4);
`else
      run8(1'b0, 8'd255, 8'd16, 8'd15, 8'd15, 1'b0, 1'b0, 10);
      run8(1'b1, 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 1'b0, 10);
`endif
      run8(1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 1);

      check("sb_empty", 64'(sb.size()), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
